// File: rtl/pckt_pkg.sv
// Shared types and constants for the packet-source arbiter and its round-robin picker.
package pckt_pkg;

  localparam int PKT_NSRC   = 4;
  localparam int PKT_IWIDTH = 8;
  localparam int SRCW       = $clog2(PKT_NSRC);

  typedef logic [0:0] state_e;
  localparam state_e IDLE   = 1'b0;
  localparam state_e LOCKED = 1'b1;

  typedef struct packed {
    logic [PKT_IWIDTH*8-1:0] data;
    logic                    sop;
    logic                    eop;
    logic [PKT_IWIDTH-1:0]   empty;
    logic                    error;
  } beat_t;

  function automatic int wrap_inc(input int v, input int n);
    return (v + 32'sd1 >= n) ? 32'sd0 : v + 32'sd1;
  endfunction

endpackage

// File: rtl/pckt_src_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping N-1 -> 0.
module rr_arbiter #(
  parameter int N = 4,
  parameter int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] gnt,
  output logic [W-1:0] gnt_idx,
  output logic         any
);

  // Rotating priority scan starting at ptr
  always_comb begin
    int idx;
    idx     = 0;
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!any && req[idx]) begin
        any      = 1'b1;
        gnt[idx] = 1'b1;
        gnt_idx  = W'(idx);
      end else begin
        any = any;
      end
    end
  end

endmodule

// File: rtl/pckt_src_arbiter.sv
// Packet-granular round-robin arbiter feeding the single packet-decoder input.
// Grant is held from SOP to EOP; non-SOP beats seen while idle are dropped and counted.
module pckt_src_arbiter
  import pckt_pkg::*;
#(
  parameter int NSRC   = PKT_NSRC,
  parameter int IWIDTH = PKT_IWIDTH,
  parameter int CNTW   = 16,
  localparam int SW    = (NSRC > 1) ? $clog2(NSRC) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NSRC-1:0]          src_valid,
  input  logic [NSRC-1:0]          src_sop,
  input  logic [NSRC-1:0]          src_eop,
  input  logic [NSRC*IWIDTH*8-1:0] src_data,
  input  logic [NSRC*IWIDTH-1:0]   src_empty,
  input  logic [NSRC-1:0]          src_error,
  output logic [NSRC-1:0]          src_ready,
  input  logic                     ready_out_b,
  output logic                     out_valid,
  output logic                     out_sop,
  output logic                     out_eop,
  output logic [IWIDTH*8-1:0]      out_data,
  output logic [IWIDTH-1:0]        out_empty,
  output logic                     out_error,
  output logic [SW-1:0]            out_src,
  output logic                     busy,
  output logic [CNTW-1:0]          drop_cnt
);

  state_e          state_r;
  logic [SW-1:0]   owner_r, ptr_r, out_src_r;
  logic            cool_r, out_valid_r;
  beat_t           out_beat_r, sel_beat_s;
  logic [CNTW-1:0] drop_cnt_r;

  logic [NSRC-1:0] cand_s, gnt_s, ready_s;
  logic [SW-1:0]   gnt_idx_s, sel_s, low_s;
  logic            any_s, fwd_s, drop_s;

  assign cand_s = src_valid & src_sop;

  rr_arbiter #(.N(NSRC), .W(SW)) u_rr (
    .req     (cand_s),
    .ptr     (ptr_r),
    .gnt     (gnt_s),
    .gnt_idx (gnt_idx_s),
    .any     (any_s)
  );

  // Lowest-index valid source, the drop target when no SOP candidate exists
  always_comb begin
    low_s = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      low_s = src_valid[i] ? SW'(i) : low_s;
    end
  end

  // Grant: at most one src_ready; cool_r forces a dead cycle after a locked packet ends
  always_comb begin
    ready_s = '0;
    sel_s   = '0;
    fwd_s   = 1'b0;
    drop_s  = 1'b0;
    if (!rst && !ready_out_b && !cool_r) begin
      case (state_r)
        IDLE: begin
          if (any_s) begin
            ready_s = gnt_s;
            sel_s   = gnt_idx_s;
            fwd_s   = 1'b1;
          end else if (|src_valid) begin
            ready_s[low_s] = 1'b1;
            drop_s         = 1'b1;
          end else begin
            drop_s = 1'b0;
          end
        end
        LOCKED: begin
          ready_s[owner_r] = 1'b1;
          sel_s            = owner_r;
          fwd_s            = src_valid[owner_r];
        end
        default: begin
          ready_s = '0;
        end
      endcase
    end else begin
      ready_s = '0;
    end
  end

  // Selected beat; an SOP arriving inside a locked packet is flagged as an error
  always_comb begin
    sel_beat_s.data  = src_data[int'(sel_s)*IWIDTH*8 +: IWIDTH*8];
    sel_beat_s.sop   = src_sop[sel_s];
    sel_beat_s.eop   = src_eop[sel_s];
    sel_beat_s.empty = src_empty[int'(sel_s)*IWIDTH +: IWIDTH];
    sel_beat_s.error = src_error[sel_s] | ((state_r == LOCKED) & src_sop[sel_s]);
  end

  // FSM, owner and round-robin pointer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      owner_r <= '0;
      ptr_r   <= '0;
      cool_r  <= 1'b0;
    end else begin
      cool_r <= 1'b0;
      if (fwd_s && (state_r == IDLE)) begin
        owner_r <= sel_s;
        ptr_r   <= SW'(wrap_inc(int'(sel_s), NSRC));
        state_r <= src_eop[sel_s] ? IDLE : LOCKED;
      end else if (fwd_s && src_eop[sel_s]) begin
        state_r <= IDLE;
        cool_r  <= 1'b1;
      end else begin
        state_r <= state_r;
      end
    end
  end

  // Output register: one beat of latency
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_r <= 1'b0;
      out_beat_r  <= '0;
      out_src_r   <= '0;
    end else begin
      out_valid_r <= fwd_s;
      if (fwd_s) begin
        out_beat_r <= sel_beat_s;
        out_src_r  <= sel_s;
      end else begin
        out_src_r <= out_src_r;
      end
    end
  end

  // Saturating drop counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_cnt_r <= '0;
    end else if (drop_s && (drop_cnt_r != {CNTW{1'b1}})) begin
      drop_cnt_r <= drop_cnt_r + {{(CNTW-1){1'b0}}, 1'b1};
    end else begin
      drop_cnt_r <= drop_cnt_r;
    end
  end

  assign src_ready = ready_s;
  assign busy      = (state_r == LOCKED);
  assign out_valid = out_valid_r;
  assign out_sop   = out_beat_r.sop;
  assign out_eop   = out_beat_r.eop;
  assign out_data  = out_beat_r.data;
  assign out_empty = out_beat_r.empty;
  assign out_error = out_beat_r.error;
  assign out_src   = out_src_r;
  assign drop_cnt  = drop_cnt_r;

endmodule

// File: tb/tb_pckt_src_arbiter.sv
// Directed bench for pckt_src_arbiter (NSRC=4, IWIDTH=8, CNTW=16).
module tb_pckt_src_arbiter;

  logic         clk;
  logic         rst;
  logic [3:0]   src_valid, src_sop, src_eop, src_error, src_ready;
  logic [255:0] src_data;
  logic [31:0]  src_empty;
  logic         ready_out_b;
  logic         out_valid, out_sop, out_eop, out_error, busy;
  logic [63:0]  out_data;
  logic [7:0]   out_empty;
  logic [1:0]   out_src;
  logic [15:0]  drop_cnt;

  int checks = 0;
  int errors = 0;

  pckt_src_arbiter #(.NSRC(4), .IWIDTH(8), .CNTW(16)) dut (
    .clk(clk), .rst(rst),
    .src_valid(src_valid), .src_sop(src_sop), .src_eop(src_eop),
    .src_data(src_data), .src_empty(src_empty), .src_error(src_error),
    .src_ready(src_ready), .ready_out_b(ready_out_b),
    .out_valid(out_valid), .out_sop(out_sop), .out_eop(out_eop),
    .out_data(out_data), .out_empty(out_empty), .out_error(out_error),
    .out_src(out_src), .busy(busy), .drop_cnt(drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_src(input int i, input logic v, input logic s, input logic e,
                         input logic [7:0] b, input logic [7:0] emp);
    src_valid[i]          = v;
    src_sop[i]            = s;
    src_eop[i]            = e;
    src_error[i]          = 1'b0;
    src_data[i*64 +: 64]  = {8{b}};
    src_empty[i*8 +: 8]   = emp;
  endtask

  task automatic idle_all();
    src_valid = 4'b0; src_sop = 4'b0; src_eop = 4'b0; src_error = 4'b0;
    src_data = '0; src_empty = '0;
  endtask

  initial begin
    int bc[4];
    logic [3:0] rdy;
    int es, eb;

    rst = 1'b1;
    ready_out_b = 1'b0;
    idle_all();
    set_src(0, 1'b1, 1'b1, 1'b1, 8'h77, 8'h00);
    tick(); tick();
    check("rst_ready", 64'(src_ready), 64'd0);
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_drop", 64'(drop_cnt), 64'd0);
    idle_all();
    rst = 1'b0;
    tick();

    // Test 1: four 3-beat packets at once, served 0,1,2,3 with one bubble between
    for (int i = 0; i < 4; i++) bc[i] = 0;
    for (int cyc = 0; cyc < 16; cyc++) begin
      for (int i = 0; i < 4; i++) begin
        if (bc[i] < 3)
          set_src(i, 1'b1, bc[i] == 0, bc[i] == 2, 8'(i*16 + bc[i]), (bc[i] == 2) ? 8'hF0 : 8'h00);
        else
          set_src(i, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
      end
      #1 rdy = src_ready;
      tick();
      for (int i = 0; i < 4; i++) if (rdy[i] && bc[i] < 3) bc[i]++;
      es = cyc / 4;
      eb = cyc % 4;
      check("t1_valid", 64'(out_valid), 64'(eb < 3));
      if (eb < 3) begin
        check("t1_src", 64'(out_src), 64'(es));
        check("t1_data", out_data, {8{8'(es*16 + eb)}});
        check("t1_sop", 64'(out_sop), 64'(eb == 0));
        check("t1_eop", 64'(out_eop), 64'(eb == 2));
        check("t1_empty", 64'(out_empty), (eb == 2) ? 64'hF0 : 64'h00);
      end
    end
    idle_all();
    tick();

    // Test 2: back-to-back single-beat packets from src2
    set_src(2, 1'b1, 1'b1, 1'b1, 8'hA5, 8'h00);
    for (int n = 0; n < 4; n++) begin
      #1 check("t2_ready", 64'(src_ready), 64'h4);
      tick();
      check("t2_valid", 64'(out_valid), 64'd1);
      check("t2_src", 64'(out_src), 64'd2);
      check("t2_busy", 64'(busy), 64'd0);
    end
    idle_all();
    tick();
    check("t2_gap", 64'(out_valid), 64'd0);

    // Test 3: backpressure in the middle of a src1 packet
    set_src(1, 1'b1, 1'b1, 1'b0, 8'h10, 8'h00);
    #1 check("t3_ready0", 64'(src_ready), 64'h2);
    tick();
    check("t3_b0", out_data, {8{8'h10}});
    set_src(1, 1'b1, 1'b0, 1'b0, 8'h11, 8'h00);
    tick();
    check("t3_b1", out_data, {8{8'h11}});
    check("t3_b1v", 64'(out_valid), 64'd1);
    set_src(1, 1'b1, 1'b0, 1'b0, 8'h12, 8'h00);
    ready_out_b = 1'b1;
    for (int n = 0; n < 5; n++) begin
      #1 check("t3_bp_ready", 64'(src_ready), 64'd0);
      tick();
      check("t3_bp_valid", 64'(out_valid), 64'd0);
      check("t3_bp_busy", 64'(busy), 64'd1);
    end
    ready_out_b = 1'b0;
    #1 check("t3_resume_ready", 64'(src_ready), 64'h2);
    tick();
    check("t3_b2", out_data, {8{8'h12}});
    check("t3_b2v", 64'(out_valid), 64'd1);
    set_src(1, 1'b1, 1'b0, 1'b1, 8'h13, 8'h00);
    tick();
    check("t3_b3", out_data, {8{8'h13}});
    check("t3_b3eop", 64'(out_eop), 64'd1);
    idle_all();
    tick();
    check("t3_after_valid", 64'(out_valid), 64'd0);
    check("t3_after_busy", 64'(busy), 64'd0);

    // Test 4: non-SOP beat while idle is dropped; counter saturates
    set_src(3, 1'b1, 1'b0, 1'b0, 8'h33, 8'h00);
    #1 check("t4_ready", 64'(src_ready), 64'h8);
    tick();
    check("t4_valid", 64'(out_valid), 64'd0);
    check("t4_drop1", 64'(drop_cnt), 64'd1);
    for (int n = 1; n < 65535; n++) tick();
    check("t4_drop_max", 64'(drop_cnt), 64'hFFFF);
    tick();
    check("t4_drop_sat", 64'(drop_cnt), 64'hFFFF);
    check("t4_valid_end", 64'(out_valid), 64'd0);
    idle_all();
    tick();

    // Test 5: SOP inside a locked packet is forwarded with error
    set_src(0, 1'b1, 1'b1, 1'b0, 8'h01, 8'h00);
    #1 check("t5_ready", 64'(src_ready), 64'h1);
    tick();
    check("t5_b0_sop", 64'(out_sop), 64'd1);
    check("t5_b0_err", 64'(out_error), 64'd0);
    set_src(0, 1'b1, 1'b0, 1'b0, 8'h02, 8'h00);
    tick();
    check("t5_b1_sop", 64'(out_sop), 64'd0);
    set_src(0, 1'b1, 1'b1, 1'b0, 8'h03, 8'h00);
    tick();
    check("t5_b2_sop", 64'(out_sop), 64'd1);
    check("t5_b2_err", 64'(out_error), 64'd1);
    check("t5_b2_data", out_data, {8{8'h03}});
    check("t5_b2_busy", 64'(busy), 64'd1);
    set_src(0, 1'b1, 1'b0, 1'b1, 8'h04, 8'h00);
    tick();
    check("t5_b3_eop", 64'(out_eop), 64'd1);
    check("t5_b3_err", 64'(out_error), 64'd0);
    check("t5_b3_busy", 64'(busy), 64'd0);
    idle_all();
    tick();

    // Test 6: reset mid-packet, then pointer restarts at 0
    set_src(2, 1'b1, 1'b1, 1'b0, 8'h20, 8'h00);
    tick();
    set_src(2, 1'b1, 1'b0, 1'b0, 8'h21, 8'h00);
    tick();
    check("t6_pre_busy", 64'(busy), 64'd1);
    rst = 1'b1;
    #1;
    check("t6_rst_valid", 64'(out_valid), 64'd0);
    check("t6_rst_busy", 64'(busy), 64'd0);
    check("t6_rst_ready", 64'(src_ready), 64'd0);
    check("t6_rst_drop", 64'(drop_cnt), 64'd0);
    check("t6_rst_data", out_data, 64'd0);
    tick();
    rst = 1'b0;
    idle_all();
    set_src(1, 1'b1, 1'b1, 1'b0, 8'h40, 8'h00);
    set_src(3, 1'b1, 1'b1, 1'b0, 8'h60, 8'h00);
    #1 check("t6_ptr0_ready", 64'(src_ready), 64'h2);
    tick();
    check("t6_out_src", 64'(out_src), 64'd1);
    check("t6_out_valid", 64'(out_valid), 64'd1);
    idle_all();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
